hangman_controller: RTL and testbench
=====================================

HANGMAN_CONTROLLER -- requirements
Module: hangman_controller

Interface
REQ-001 SHALL have parameters, one per line:
- WORD_LEN, 7, characters per secret word.
- MAX_MISSES, 6, wrong guesses that end the game.
- BLANK, 7'h5F, 7-bit ASCII underscore shown for unrevealed characters.

REQ-002 SHALL have ports, one per line:
- clk, in, 1, sole clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- new_game, in, 1, single-cycle request to load word_in and start a game.
- word_in, in, 7*WORD_LEN, secret word; char i at [7i+6:7i], char 0 leftmost.
- guess_valid, in, 1, guess offered.
- guess, in, 7, ASCII guess character.
- guess_ready, out, 1, controller accepts a guess this cycle.
- disp, out, 7*WORD_LEN, revealed characters or BLANK, same packing as word_in.
- misses, out, 3, wrong-guess count.
- result_valid, out, 1, one-cycle pulse when a guess finishes.
- hit, out, 1, the guess revealed at least one new character; valid with result_valid.
- repeat_guess, out, 1, the guess matched only already-revealed characters; valid with result_valid.
- game_won, out, 1, level; all characters revealed.
- game_lost, out, 1, level; misses reached MAX_MISSES.

Function
REQ-003 SHALL implement FSM states IDLE, READY, SCAN, UPDATE, WON, LOST.
REQ-004 SHALL move from IDLE to READY on new_game: latch word_in, clear the reveal mask, clear misses.
REQ-005 SHALL give new_game priority over every other event in every state, including mid-SCAN. The next state is READY, the mask and misses are cleared, and no result_valid is produced for an aborted guess.
REQ-006 SHALL drive guess_ready=1 only in READY. A handshake (guess_valid & guess_ready) latches guess, sets idx=0, clears the match flags, and enters SCAN.
REQ-007 SHALL spend exactly WORD_LEN cycles in SCAN, comparing word[idx]==guess once per cycle with idx incrementing.
- A match with mask[idx]=0 sets mask[idx] and the hit flag.
- A match with mask[idx]=1 sets the repeat flag.
REQ-008 SHALL compare exact 7-bit values, with no case folding.
REQ-009 SHALL leave SCAN for UPDATE after idx==WORD_LEN-1, with no idx wrap beyond WORD_LEN-1.
REQ-010 SHALL behave as follows in UPDATE, lasting one cycle:
- Assert result_valid.
- Drive hit = hit flag, and repeat_guess = repeat flag & ~hit flag.
- Increment misses iff both flags are 0; misses saturates at MAX_MISSES.
REQ-011 SHALL choose the next state out of UPDATE in this priority order: all mask bits set -> WON; updated misses == MAX_MISSES -> LOST; otherwise READY.
REQ-012 SHALL make latency fixed: result_valid is high in the 8th cycle after the acceptance edge (WORD_LEN+1). misses, game_won and game_lost take their new values on the edge ending that cycle.
REQ-013 SHALL count a repeated wrong letter as a new miss each time (no guessed-letter history).
REQ-014 SHALL hold WON/LOST until new_game, with guess_ready=0. guess_valid is ignored in every state other than READY.
REQ-015 SHALL form disp[i] as follows: in LOST, word[i]; otherwise mask[i] ? word[i] : BLANK. disp depends only on registered state.
REQ-016 SHALL assert game_won iff state==WON and game_lost iff state==LOST.

Reset
REQ-017 SHALL, on rst_n low asynchronously, force: state IDLE, word register 0, mask 0, idx 0, misses 0, flags 0, guess_ready 0, result_valid 0, hit 0, repeat_guess 0, game_won 0, game_lost 0, disp all BLANK.
REQ-018 SHALL abandon an in-progress SCAN on reset with no result_valid, and remain in IDLE after rst_n rises until new_game.

Structure
REQ-019 SHALL place WORD_LEN, MAX_MISSES, BLANK and the state enum in shared package hangman_pkg.
REQ-020 SHALL implement disp generation as one sub-module, hangman_display_mux (inputs word, mask, lost; output disp), reusable by the VGA/7-seg text path.

Verification
REQ-021 Reset, then new_game with "HANGMAN", then guess 'A' (7'h41) -> result_valid 8 cycles after acceptance, hit=1, disp "_A___A_", misses=0.
REQ-022 Next guess 'Z' -> hit=0, repeat_guess=0, misses=1, disp unchanged, back to READY.
REQ-023 Guess 'A' again -> repeat_guess=1, hit=0, misses stays 1.
REQ-024 Guesses 'H','N','G','M' -> the 'M' result gives game_won=1, disp "HANGMAN", guess_ready=0; a further guess_valid is ignored.
REQ-025 New game, then guesses 'Q','W','E','R','T','Y' -> misses counts 1..6; game_lost=1 after 'Y'; disp "HANGMAN"; a 7th guess is not accepted.
REQ-026 Abort cases:
- new_game asserted in the 3rd SCAN cycle -> READY next cycle, mask=0, no result_valid.
- rst_n low mid-SCAN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared constants and FSM encoding for the hangman game controller.
package hangman_pkg;

  localparam int         WORD_LEN   = 7;
  localparam int         MAX_MISSES = 6;
  localparam logic [6:0] BLANK      = 7'h5F;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    SCAN,
    UPDATE,
    WON,
    LOST
  } state_t;

endpackage

// File: rtl/hangman_display_mux.sv
// Builds the visible word: revealed characters or BLANK, whole word once lost.
module hangman_display_mux #(
  parameter int         WORD_LEN = hangman_pkg::WORD_LEN,
  parameter logic [6:0] BLANK    = hangman_pkg::BLANK
) (
  input  logic [7*WORD_LEN-1:0] word,
  input  logic [WORD_LEN-1:0]   mask,
  input  logic                  lost,
  output logic [7*WORD_LEN-1:0] disp
);

  for (genvar i = 0; i < WORD_LEN; i++) begin : g_char
    assign disp[7*i +: 7] = (lost || mask[i]) ? word[7*i +: 7] : BLANK;
  end

endmodule

// File: rtl/hangman_controller.sv
// Hangman game controller: one guess is scanned against the secret word one
// character per cycle, then scored in a single UPDATE cycle.
module hangman_controller
  import hangman_pkg::*;
#(
  parameter int         WORD_LEN   = hangman_pkg::WORD_LEN,
  parameter int         MAX_MISSES = hangman_pkg::MAX_MISSES,
  parameter logic [6:0] BLANK      = hangman_pkg::BLANK
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  new_game,
  input  logic [7*WORD_LEN-1:0] word_in,
  input  logic                  guess_valid,
  input  logic [6:0]            guess,
  output logic                  guess_ready,
  output logic [7*WORD_LEN-1:0] disp,
  output logic [2:0]            misses,
  output logic                  result_valid,
  output logic                  hit,
  output logic                  repeat_guess,
  output logic                  game_won,
  output logic                  game_lost
);

  localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_LEN - 1);
  localparam logic [2:0]       MISS_SAT  = 3'(MAX_MISSES);

  state_t                state_q, state_d;
  logic [7*WORD_LEN-1:0] word_q;
  logic [WORD_LEN-1:0]   mask_q;
  logic [IDX_W-1:0]      idx_q;
  logic [2:0]            misses_q;
  logic [6:0]            guess_q;
  logic                  hit_q;
  logic                  rep_q;

  logic [6:0] cur_char;
  logic       char_match;
  logic       miss;
  logic [2:0] misses_next;

  assign cur_char   = word_q[7*int'(idx_q) +: 7];
  assign char_match = (cur_char == guess_q);
  assign miss       = ~hit_q & ~rep_q;
  assign misses_next = (miss && (misses_q != MISS_SAT)) ? misses_q + 3'd1 : misses_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: state_d gets its hold value before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    if (new_game) begin
      state_d = READY;
    end else begin
      unique case (state_q)
        IDLE:   state_d = IDLE;
        READY:  if (guess_valid) state_d = SCAN;
        SCAN:   if (idx_q == LAST_IDX) state_d = UPDATE;
        UPDATE: begin
          if (&mask_q)                       state_d = WON;
          else if (misses_next == MISS_SAT)  state_d = LOST;
          else                               state_d = READY;
        end
        WON:    state_d = WON;
        LOST:   state_d = LOST;
        default: state_d = IDLE;
      endcase
    end
  end

  // The word register is reset too, so disp is defined (all BLANK) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      mask_q   <= '0;
      idx_q    <= '0;
      misses_q <= '0;
      guess_q  <= '0;
      hit_q    <= 1'b0;
      rep_q    <= 1'b0;
    end else if (new_game) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      word_q   <= word_in;
      mask_q   <= '0;
      idx_q    <= '0;
      misses_q <= '0;
      hit_q    <= 1'b0;
      rep_q    <= 1'b0;
    end else begin
      unique case (state_q)
        READY: begin
          if (guess_valid) begin
            guess_q <= guess;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            rep_q   <= 1'b0;
          end
        end
        SCAN: begin
          if (char_match) begin
            if (!mask_q[idx_q]) begin
              mask_q[idx_q] <= 1'b1;
              hit_q         <= 1'b1;
            end else begin
              rep_q <= 1'b1;
            end
          end
          if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        end
        UPDATE:  misses_q <= misses_next;
        default: ;
      endcase
    end
  end

  // Handshake and result outputs are decoded from registered state only.
  assign guess_ready  = (state_q == READY);
  assign result_valid = (state_q == UPDATE);
  assign hit          = (state_q == UPDATE) & hit_q;
  assign repeat_guess = (state_q == UPDATE) & rep_q & ~hit_q;
  assign game_won     = (state_q == WON);
  assign game_lost    = (state_q == LOST);
  assign misses       = misses_q;

  hangman_display_mux #(
    .WORD_LEN (WORD_LEN),
    .BLANK    (BLANK)
  ) u_display_mux (
    .word (word_q),
    .mask (mask_q),
    .lost (state_q == LOST),
    .disp (disp)
  );

endmodule

// File: tb/tb_hangman_controller.sv
// Directed bench for hangman_controller: win, loss, repeat, abort and reset cases.
module tb_hangman_controller;

  localparam int WL = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          new_game;
  logic [7*WL-1:0] word_in;
  logic          guess_valid;
  logic [6:0]    guess;
  logic          guess_ready;
  logic [7*WL-1:0] disp;
  logic [2:0]    misses;
  logic          result_valid;
  logic          hit;
  logic          repeat_guess;
  logic          game_won;
  logic          game_lost;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hangman_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_game     (new_game),
    .word_in      (word_in),
    .guess_valid  (guess_valid),
    .guess        (guess),
    .guess_ready  (guess_ready),
    .disp         (disp),
    .misses       (misses),
    .result_valid (result_valid),
    .hit          (hit),
    .repeat_guess (repeat_guess),
    .game_won     (game_won),
    .game_lost    (game_lost)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Char 0 of the string goes to the least significant 7 bits.
  function automatic logic [7*WL-1:0] pack7(input string s);
    logic [7*WL-1:0] r;
    byte b;
    r = '0;
    for (int i = 0; i < WL; i++) begin
      b = s[i];
      r[7*i +: 7] = b[6:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input string w);
    word_in  = pack7(w);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  // Offers one guess; returns once the DUT is in cycle 1 after the acceptance edge.
  task automatic accept(input byte ch);
    int n;
    n = 0;
    while (!guess_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_timeout", 64'(n < 20), 64'd1);
    guess       = ch[6:0];
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
  endtask

  task automatic do_guess(input byte ch, input logic e_hit, input logic e_rep,
                          input logic [2:0] e_miss, input string e_disp,
                          input logic e_won, input logic e_lost);
    int n;
    accept(ch);
    n = 1;
    while (!result_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'd8);
    check("hit", 64'(hit), 64'(e_hit));
    check("repeat", 64'(repeat_guess), 64'(e_rep));
    tick();
    check("misses", 64'(misses), 64'(e_miss));
    check("disp", 64'(disp), 64'(pack7(e_disp)));
    check("won", 64'(game_won), 64'(e_won));
    check("lost", 64'(game_lost), 64'(e_lost));
    check("ready_after", 64'(guess_ready), 64'(!(e_won || e_lost)));
  endtask

  // Holds guess_valid for a while and reports whether any result appeared.
  task automatic offer_ignored(input byte ch, output logic seen);
    seen        = 1'b0;
    guess       = ch[6:0];
    guess_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (result_valid || guess_ready) seen = 1'b1;
    end
    guess_valid = 1'b0;
  endtask

  initial begin
    logic seen;
    rst_n       = 1'b0;
    new_game    = 1'b0;
    word_in     = '0;
    guess_valid = 1'b0;
    guess       = '0;
    #1;
    check("rst_ready", 64'(guess_ready), 64'd0);
    check("rst_disp", 64'(disp), 64'(pack7("_______")));
    check("rst_misses", 64'(misses), 64'd0);
    check("rst_flags", 64'({result_valid, hit, repeat_guess, game_won, game_lost}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_ready", 64'(guess_ready), 64'd0);

    start_game("HANGMAN");
    check("ng_ready", 64'(guess_ready), 64'd1);
    check("ng_disp", 64'(disp), 64'(pack7("_______")));

    do_guess("A", 1'b1, 1'b0, 3'd0, "_A___A_", 1'b0, 1'b0);
    do_guess("Z", 1'b0, 1'b0, 3'd1, "_A___A_", 1'b0, 1'b0);
    do_guess("A", 1'b0, 1'b1, 3'd1, "_A___A_", 1'b0, 1'b0);
    do_guess("a", 1'b0, 1'b0, 3'd2, "_A___A_", 1'b0, 1'b0);
    do_guess("H", 1'b1, 1'b0, 3'd2, "HA___A_", 1'b0, 1'b0);
    do_guess("N", 1'b1, 1'b0, 3'd2, "HAN__AN", 1'b0, 1'b0);
    do_guess("G", 1'b1, 1'b0, 3'd2, "HANG_AN", 1'b0, 1'b0);
    do_guess("M", 1'b1, 1'b0, 3'd2, "HANGMAN", 1'b1, 1'b0);
    offer_ignored("X", seen);
    check("won_ignore", 64'(seen), 64'd0);
    check("won_hold", 64'(game_won), 64'd1);
    check("won_misses", 64'(misses), 64'd2);

    start_game("HANGMAN");
    check("ng2_won", 64'(game_won), 64'd0);
    check("ng2_misses", 64'(misses), 64'd0);
    check("ng2_disp", 64'(disp), 64'(pack7("_______")));
    do_guess("Q", 1'b0, 1'b0, 3'd1, "_______", 1'b0, 1'b0);
    do_guess("W", 1'b0, 1'b0, 3'd2, "_______", 1'b0, 1'b0);
    do_guess("E", 1'b0, 1'b0, 3'd3, "_______", 1'b0, 1'b0);
    do_guess("R", 1'b0, 1'b0, 3'd4, "_______", 1'b0, 1'b0);
    do_guess("T", 1'b0, 1'b0, 3'd5, "_______", 1'b0, 1'b0);
    do_guess("Y", 1'b0, 1'b0, 3'd6, "HANGMAN", 1'b0, 1'b1);
    offer_ignored("U", seen);
    check("lost_ignore", 64'(seen), 64'd0);
    check("lost_misses", 64'(misses), 64'd6);
    check("lost_hold", 64'(game_lost), 64'd1);

    // new_game during the 3rd SCAN cycle, after 'A' at index 1 was revealed.
    start_game("HANGMAN");
    accept("A");
    tick();
    tick();
    check("abort_pre_disp", 64'(disp), 64'(pack7("_A_____")));
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("abort_ready", 64'(guess_ready), 64'd1);
    check("abort_disp", 64'(disp), 64'(pack7("_______")));
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (result_valid) seen = 1'b1;
      tick();
    end
    check("abort_no_result", 64'(seen), 64'd0);

    // Reset mid-SCAN with a miss and a revealed character on record.
    do_guess("Z", 1'b0, 1'b0, 3'd1, "_______", 1'b0, 1'b0);
    accept("A");
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst2_disp", 64'(disp), 64'(pack7("_______")));
    check("rst2_misses", 64'(misses), 64'd0);
    check("rst2_flags", 64'({guess_ready, result_valid, hit, repeat_guess, game_won, game_lost}), 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (result_valid || guess_ready) seen = 1'b1;
    end
    check("rst2_idle", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
